// File: rtl/spi_reg_bridge.sv
// ============================================================================
// Module   : spi_reg_bridge
// Brief    : Byte-level command bridge from an SPI slave to 7 r/w registers
//            plus a read-only status byte. Option: SPI_REG_BRIDGE_AUTOINC_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_reg_bridge #(
  parameter logic [7:0] REG_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       ss,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] send_buffer,
  input  logic [7:0] status_in,
  output logic [7:0] ctrl_reg,
  output logic       wr_strobe,
  output logic [2:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err
);

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
  localparam bit c_autoinc = 1'b1;
`else
  localparam bit c_autoinc = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_ss_meta;
  logic       r_ss_s;
  logic       r_ss_d;
  logic [1:0] r_live;
  logic [7:0] r_regs [0:6];
  logic [2:0] r_ptr;
  logic       r_load;
  logic       r_first;
  logic [7:0] w_rd_data;
  logic       w_ss_fall;
  logic       w_take;

  // The edge detector only trusts ss_s once it holds a genuinely sampled value,
  // so ss held low across reset release never fakes a frame start.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_ss_meta <= 1'b1;
      r_ss_s    <= 1'b1;
      r_ss_d    <= 1'b0;
      r_live    <= 2'b00;
    end else begin
      r_ss_meta <= ss;
      r_ss_s    <= r_ss_meta;
      r_live    <= {r_live[0], 1'b1};
      r_ss_d    <= r_ss_s & r_live[1];
    end
  end

  assign w_ss_fall = r_ss_d & ~r_ss_s;
  assign w_take    = c_autoinc | r_first;
  assign ctrl_reg  = r_regs[0];

  always_comb begin
    w_rd_data = status_in;
    if (r_ptr != 3'd7) w_rd_data = r_regs[r_ptr];
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= IDLE;
      for (int i = 0; i < 7; i++) r_regs[i] <= REG_RESET;
      r_ptr       <= 3'd0;
      r_load      <= 1'b0;
      r_first     <= 1'b0;
      send_buffer <= 8'h00;
      wr_strobe   <= 1'b0;
      wr_addr     <= 3'd0;
      wr_data     <= 8'h00;
      frame_err   <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      r_load    <= 1'b0;
      case (r_state)
        IDLE: begin
          send_buffer <= 8'h00;
          if (w_ss_fall) r_state <= CMD;
        end
        CMD: begin
          send_buffer <= 8'h00;
          if (rx_valid) begin
            r_ptr   <= rx_data[2:0];
            r_first <= 1'b1;
            if (rx_data[7]) begin
              r_state <= WRITE;
            end else begin
              r_state <= READ;
              r_load  <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (rx_valid) begin
            r_first <= 1'b0;
            if (c_autoinc) r_ptr <= r_ptr + 3'd1;
            if (!w_take || r_ptr == 3'd7) begin
              frame_err <= 1'b1;
            end else begin
              r_regs[r_ptr] <= rx_data;
              wr_strobe     <= 1'b1;
              wr_addr       <= r_ptr;
              wr_data       <= rx_data;
            end
          end
        end
        READ: begin
          if (r_load) send_buffer <= w_rd_data;
          if (c_autoinc && rx_valid) begin
            r_ptr  <= r_ptr + 3'd1;
            r_load <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
      // A byte arriving in the same cycle ss_s rises was still handled above.
      if (r_ss_s && r_state != IDLE) begin
        r_state     <= IDLE;
        send_buffer <= 8'h00;
      end
    end
  end

endmodule

`default_nettype wire
